// File: rtl/ha_array_accumulator_seq.sv
// Serial reducer for the 8x8 HA-array multiplier: four weighted rows summed one per clock.
// Define HA_ACC_COMP_EN to preload the accumulator with COMP_BIAS (error compensation).
module ha_array_accumulator_seq #(
  parameter logic [15:0] COMP_BIAS = 16'd34
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [8:0] ha_array_0_t,
  input  logic [6:0] ha_array_0_b,
  input  logic [8:0] ha_array_1_t,
  input  logic [6:0] ha_array_1_b,
  input  logic [8:0] ha_array_2_t,
  input  logic [6:0] ha_array_2_b,
  input  logic [8:0] ha_array_3_t,
  input  logic [6:0] ha_array_3_b,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [15:0] prod,
  output logic       ovf
);

  // state | meaning
  // IDLE  | waiting for a beat, in_ready high
  // ACC   | adding one row per clock, idx selects the row
  // DONE  | result presented, waiting for out_ready
  typedef enum logic [1:0] {IDLE = 2'd0, ACC = 2'd1, DONE = 2'd2} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [1:0]  idx;
  logic [16:0] acc;
  logic [16:0] acc_init;
  logic [16:0] row_val;
  logic [16:0] acc_sum;
  logic [8:0]  t_q [4];
  logic [6:0]  b_q [4];
  logic        accept;
  logic        last_add;

`ifdef HA_ACC_COMP_EN
  assign acc_init = {1'b0, COMP_BIAS};
`else
  // Masked rather than dropped so the parameter stays referenced in this build.
  assign acc_init = {1'b0, COMP_BIAS & 16'd0};
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = ACC;
      ACC:     if (idx == 2'd3) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    accept    = in_valid && (state == IDLE);
    last_add  = (state == ACC) && (idx == 2'd3);
  end

  // b[j] sits two places above t[j] within a row; the row itself is weighted by 4^idx.
  always_comb begin
    row_val = ({8'd0, t_q[idx]} + {8'd0, b_q[idx], 2'b00}) << {idx, 1'b0};
    acc_sum = acc + row_val;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      t_q[0] <= ha_array_0_t;
      t_q[1] <= ha_array_1_t;
      t_q[2] <= ha_array_2_t;
      t_q[3] <= ha_array_3_t;
      b_q[0] <= ha_array_0_b;
      b_q[1] <= ha_array_1_b;
      b_q[2] <= ha_array_2_b;
      b_q[3] <= ha_array_3_b;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx  <= 2'd0;
      acc  <= 17'd0;
      prod <= 16'd0;
      ovf  <= 1'b0;
    end else if (accept) begin
      idx <= 2'd0;
      acc <= acc_init;
    end else if (state == ACC) begin
      idx <= idx + 2'd1;
      acc <= acc_sum;
      if (last_add) begin
        prod <= acc_sum[15:0];
        ovf  <= acc_sum[16];
      end
    end
  end

endmodule

// File: tb/tb_ha_array_accumulator_seq.sv
// Scoreboard bench for ha_array_accumulator_seq; honours HA_ACC_COMP_EN for the bias.
module tb_ha_array_accumulator_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic in_ready, out_valid, ovf;
  logic [15:0] prod;
  logic [8:0] t_in [4];
  logic [6:0] b_in [4];

`ifdef HA_ACC_COMP_EN
  localparam logic [16:0] BIAS = 17'd34;
`else
  localparam logic [16:0] BIAS = 17'd0;
`endif

  int vectors = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = 0;
  logic [16:0] sb [$];

  ha_array_accumulator_seq #(.COMP_BIAS(16'd34)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .ha_array_0_t(t_in[0]), .ha_array_0_b(b_in[0]),
    .ha_array_1_t(t_in[1]), .ha_array_1_b(b_in[1]),
    .ha_array_2_t(t_in[2]), .ha_array_2_b(b_in[2]),
    .ha_array_3_t(t_in[3]), .ha_array_3_b(b_in[3]),
    .out_valid(out_valid), .out_ready(out_ready), .prod(prod), .ovf(ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [16:0] model();
    logic [16:0] s;
    s = BIAS;
    for (int k = 0; k < 4; k++) begin
      s = s + (17'(t_in[k]) << (2 * k)) + (17'(b_in[k]) << (2 * k + 2));
    end
    return s;
  endfunction

  task automatic set_rows(input logic [8:0] t0, t1, t2, t3,
                          input logic [6:0] b0, b1, b2, b3);
    t_in[0] = t0; t_in[1] = t1; t_in[2] = t2; t_in[3] = t3;
    b_in[0] = b0; b_in[1] = b1; b_in[2] = b2; b_in[3] = b3;
  endtask

  task automatic send_beat(output bit to);
    to = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        to = 1'b0;
        break;
      end
    end
    if (!to) begin
      sb.push_back(model());
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      acc_cyc = cyc;
    end
  endtask

  task automatic wait_result(output logic [16:0] obs, output int lat, output bit to);
    to = 1'b1;
    obs = '0;
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        obs = {ovf, prod};
        lat = cyc - acc_cyc;
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic take_result();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_rows(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    vectors++;
    if ({in_ready, out_valid, ovf, prod} !== {1'b1, 1'b0, 1'b0, 16'd0}) begin
      errors++;
      $display("FAIL reset_state got rdy=%b vld=%b ovf=%b prod=%h expected 1 0 0 0000",
               in_ready, out_valid, ovf, prod);
    end
  endtask

  task automatic test_zero();
    logic [16:0] obs, exp_v;
    int lat;
    bit to;
    set_rows(0, 0, 0, 0, 0, 0, 0, 0);
    send_beat(to);
    vectors++;
    if (to || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL zero_in_ready_drop got rdy=%b to=%0d expected 0", in_ready, to);
    end
    wait_result(obs, lat, to);
    exp_v = sb.pop_front();
    vectors++;
    if (to || obs !== exp_v || obs !== BIAS || lat != 4) begin
      errors++;
      $display("FAIL zero_result got %h lat=%0d to=%0d expected %h lat=4", obs, lat, to, exp_v);
    end
    take_result();
    @(negedge clk);
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL zero_release got rdy=%b vld=%b expected 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_single_bits();
    logic [16:0] obs, exp_v;
    logic [16:0] lit [3];
    int lat;
    bit to;
    lit[0] = 17'd1; lit[1] = 17'd64; lit[2] = 17'd16384;
    for (int c = 0; c < 3; c++) begin
      case (c)
        0: set_rows(9'h001, 0, 0, 0, 0, 0, 0, 0);
        1: set_rows(0, 0, 0, 9'h001, 0, 0, 0, 0);
        default: set_rows(0, 0, 0, 0, 0, 0, 0, 7'h40);
      endcase
      send_beat(to);
      wait_result(obs, lat, to);
      exp_v = sb.pop_front();
      vectors++;
      if (to || obs !== exp_v || obs !== lit[c] + BIAS || lat != 4) begin
        errors++;
        $display("FAIL single_bit_%0d got %h lat=%0d expected %h", c, obs, lat, lit[c] + BIAS);
      end
      take_result();
    end
  endtask

  task automatic test_all_ones();
    logic [16:0] obs, exp_v;
    int lat;
    bit to;
    set_rows(9'h1FF, 9'h1FF, 9'h1FF, 9'h1FF, 7'h7F, 7'h7F, 7'h7F, 7'h7F);
    send_beat(to);
    wait_result(obs, lat, to);
    exp_v = sb.pop_front();
    vectors++;
    if (to || obs !== exp_v || obs !== 17'h15257 + BIAS) begin
      errors++;
      $display("FAIL all_ones got %h expected %h", obs, 17'h15257 + BIAS);
    end
    take_result();
  endtask

  task automatic test_backpressure();
    logic [16:0] obs, exp_v;
    int lat;
    bit to;
    set_rows(9'h1FF, 9'h0AA, 9'h155, 9'h0F0, 7'h55, 7'h2A, 7'h7F, 7'h01);
    send_beat(to);
    set_rows(0, 0, 0, 0, 0, 0, 0, 0);
    in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1 in_valid = 1'b0;
    wait_result(obs, lat, to);
    exp_v = sb.pop_front();
    vectors++;
    if (to || obs !== exp_v || lat != 4) begin
      errors++;
      $display("FAIL bp_result got %h lat=%0d expected %h lat=4", obs, lat, exp_v);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      vectors++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || {ovf, prod} !== exp_v) begin
        errors++;
        $display("FAIL bp_hold_%0d got vld=%b rdy=%b val=%h expected 1 0 %h",
                 i, out_valid, in_ready, {ovf, prod}, exp_v);
      end
    end
    take_result();
    @(negedge clk);
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || {ovf, prod} !== exp_v) begin
      errors++;
      $display("FAIL bp_release got rdy=%b vld=%b val=%h expected 1 0 %h",
               in_ready, out_valid, {ovf, prod}, exp_v);
    end
    repeat (6) @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_no_extra_beat got vld=%b rdy=%b expected 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid_acc();
    logic [16:0] obs, exp_v;
    int lat;
    bit to;
    set_rows(9'h1FF, 9'h1FF, 9'h1FF, 9'h1FF, 7'h7F, 7'h7F, 7'h7F, 7'h7F);
    send_beat(to);
    void'(sb.pop_back());
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    vectors++;
    if ({in_ready, out_valid, ovf, prod} !== {1'b1, 1'b0, 1'b0, 16'd0}) begin
      errors++;
      $display("FAIL mid_acc_reset got rdy=%b vld=%b ovf=%b prod=%h expected 1 0 0 0000",
               in_ready, out_valid, ovf, prod);
    end
    repeat (6) @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_acc_discard got vld=%b expected 0", out_valid);
    end
    set_rows(9'h003, 0, 0, 0, 0, 0, 0, 0);
    send_beat(to);
    wait_result(obs, lat, to);
    exp_v = sb.pop_front();
    vectors++;
    if (to || obs !== exp_v || obs !== 17'd3 + BIAS || lat != 4) begin
      errors++;
      $display("FAIL post_reset_beat got %h lat=%0d expected %h", obs, lat, 17'd3 + BIAS);
    end
    take_result();
  endtask

  task automatic test_back_to_back();
    logic [16:0] obs, exp_v;
    int lat, prev;
    bit to;
    prev = 0;
    for (int n = 0; n < 6; n++) begin
      set_rows(9'($urandom), 9'($urandom), 9'($urandom), 9'($urandom),
               7'($urandom), 7'($urandom), 7'($urandom), 7'($urandom));
      send_beat(to);
      if (n > 0) begin
        vectors++;
        if (acc_cyc - prev != 6) begin
          errors++;
          $display("FAIL b2b_interval_%0d got %0d expected 6", n, acc_cyc - prev);
        end
      end
      prev = acc_cyc;
      wait_result(obs, lat, to);
      exp_v = sb.pop_front();
      vectors++;
      if (to || obs !== exp_v || lat != 4) begin
        errors++;
        $display("FAIL b2b_result_%0d got %h lat=%0d expected %h lat=4", n, obs, lat, exp_v);
      end
      take_result();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_zero();
    test_single_bits();
    test_all_ones();
    test_backpressure();
    test_reset_mid_acc();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
